// File: rtl/m_stage_arbiter_if.sv
// Handshake bundle for the 2:1 merge stage: two Send/Ack sources in, one Send/Ack sink out.
// The slave modport is the arbiter's view; the master modport is the producer/consumer side.
interface m_stage_arbiter_if #(
    parameter int W = 32
);
    logic         send_in_a;
    logic [W-1:0] packet_in_a;
    logic         ack_out_a;
    logic         send_in_b;
    logic [W-1:0] packet_in_b;
    logic         ack_out_b;
    logic         send_out;
    logic [W-1:0] packet_out;
    logic         ack_in;
    logic         grant_src;
    logic         locked;

    modport slave (
        input  send_in_a, packet_in_a, send_in_b, packet_in_b, ack_in,
        output ack_out_a, ack_out_b, send_out, packet_out, grant_src, locked
    );

    modport master (
        output send_in_a, packet_in_a, send_in_b, packet_in_b, ack_in,
        input  ack_out_a, ack_out_b, send_out, packet_out, grant_src, locked
    );
endinterface

// File: rtl/m_stage_arbiter.sv
// Round-robin 2:1 merge into a one-entry output register.
// A set PAIR bit locks the grant to its source until that source sends a packet with PAIR clear.
//   state        | meaning
//   ST_UNLOCKED  | both sources eligible, RR pointer arbitrates
//   ST_LOCK_A    | only A eligible, pair/chain from A in progress
//   ST_LOCK_B    | only B eligible, pair/chain from B in progress
module m_stage_arbiter #(
    parameter int W        = 32,
    parameter int PAIR_BIT = W - 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    m_stage_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCK_A   = 2'd1,
        ST_LOCK_B   = 2'd2
    } lock_state_t;

    lock_state_t  r_state;
    lock_state_t  w_state_nxt;
    logic         r_send_out;
    logic [W-1:0] r_packet_out;
    logic         r_grant_src;
    logic         r_rr_b;

    logic         w_can_load;
    logic         w_req_a;
    logic         w_req_b;
    logic         w_ack_a;
    logic         w_ack_b;
    logic         w_accept;
    logic [W-1:0] w_pkt_sel;

    // Loading while the sink drains gives one packet per cycle without bubbles.
    assign w_can_load = !r_send_out | bus.ack_in;
    assign w_req_a    = bus.send_in_a & (r_state != ST_LOCK_B);
    assign w_req_b    = bus.send_in_b & (r_state != ST_LOCK_A);
    assign w_ack_a    = w_can_load & i_rst_n & w_req_a & (!w_req_b | !r_rr_b);
    assign w_ack_b    = w_can_load & i_rst_n & w_req_b & (!w_req_a |  r_rr_b);
    assign w_accept   = w_ack_a | w_ack_b;
    assign w_pkt_sel  = w_ack_b ? bus.packet_in_b : bus.packet_in_a;

    assign bus.ack_out_a  = w_ack_a;
    assign bus.ack_out_b  = w_ack_b;
    assign bus.send_out   = r_send_out;
    assign bus.packet_out = r_packet_out;
    assign bus.grant_src  = r_grant_src;
    assign bus.locked     = (r_state != ST_UNLOCKED);

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_pkt_sel[PAIR_BIT]) begin
                w_state_nxt = w_ack_b ? ST_LOCK_B : ST_LOCK_A;
            end else begin
                w_state_nxt = ST_UNLOCKED;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_UNLOCKED;
            r_send_out   <= 1'b0;
            r_packet_out <= '0;
            r_grant_src  <= 1'b0;
            r_rr_b       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_send_out   <= 1'b1;
                r_packet_out <= w_pkt_sel;
                r_grant_src  <= w_ack_b;
                r_rr_b       <= w_ack_a;
            end else if (r_send_out && bus.ack_in) begin
                r_send_out <= 1'b0;
            end
        end
    end
endmodule
